sbus_responder: RTL and testbench



---
 rtl/sbus_pkg.sv | 36 +++
 rtl/sbus_regfile.sv | 57 +++++
 rtl/sbus_responder.sv | 187 ++++++++++++++++++
 tb/tb_sbus_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbus_pkg.sv
// ---------------------------------------------------------------------------
// sbus_pkg
// Shared types for the simple-bus responder:
//   sbus_state_e : responder FSM states (IDLE, WAIT, RESP)
//   sbus_req_t   : request fields {we, addr, wdata, be} at default widths
//   sbus_rsp_t   : response fields {err, rdata} at default widths
// Default widths are exported as localparams. Modules take their real
// widths through parameters, so these only set the defaults.
// ---------------------------------------------------------------------------
package sbus_pkg;

    localparam int SBUS_ADDR_W = 8;
    localparam int SBUS_DATA_W = 32;
    localparam int SBUS_BE_W   = SBUS_DATA_W / 8;
    localparam int SBUS_DEPTH  = 64;
    localparam int SBUS_WAIT   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } sbus_state_e;

    typedef struct packed {
        logic                   we;
        logic [SBUS_ADDR_W-1:0] addr;
        logic [SBUS_DATA_W-1:0] wdata;
        logic [SBUS_BE_W-1:0]   be;
    } sbus_req_t;

    typedef struct packed {
        logic                   err;
        logic [SBUS_DATA_W-1:0] rdata;
    } sbus_rsp_t;

endpackage

// File: rtl/sbus_regfile.sv
// ---------------------------------------------------------------------------
// sbus_regfile
// Word-addressed register file with per-byte write enables.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, clears every word
//   wr_en  : write strobe (ignored for out-of-range addresses)
//   addr   : word address
//   wdata  : write data
//   be     : byte enables, one bit per data byte
//   rdata  : combinational read of addr, 0 when out of range
// ---------------------------------------------------------------------------
module sbus_regfile
    import sbus_pkg::*;
#(
    parameter int ADDR_W = SBUS_ADDR_W,
    parameter int DATA_W = SBUS_DATA_W,
    parameter int DEPTH  = SBUS_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_mask;
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;

    // Full-width compare: one extra bit so DEPTH == 2**ADDR_W does not wrap.
    assign w_in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
    assign w_idx      = addr[IDX_W-1:0];

    // Expand byte enables into a bit mask.
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_mask
        assign w_mask[gi*8 +: 8] = {8{be[gi]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en && w_in_range) begin
            r_mem[w_idx] <= (r_mem[w_idx] & ~w_mask) | (wdata & w_mask);
        end
    end

    assign rdata = w_in_range ? r_mem[w_idx] : '0;

endmodule

// File: rtl/sbus_responder.sv
// ---------------------------------------------------------------------------
// sbus_responder
// Target end of the simple request/response bus. Accepts one request at a
// time, waits WAIT_CYCLES states, performs the register-file access on the
// edge that enters RESP and holds the response until it is taken.
//   clk, rst_n            : clock / asynchronous active-low reset
//   req_valid/req_ready   : request handshake
//   req_we/addr/wdata/be  : request payload (word address, byte enables)
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rdata/rsp_err     : read data (0 for writes/errors), range error
//   rsp_parity            : only when SBUS_RSP_PARITY_EN is defined; XOR of
//                           {rsp_err, rsp_rdata}, registered with them
// ---------------------------------------------------------------------------
module sbus_responder
    import sbus_pkg::*;
#(
    parameter int ADDR_W      = SBUS_ADDR_W,
    parameter int DATA_W      = SBUS_DATA_W,
    parameter int DEPTH       = SBUS_DEPTH,
    parameter int WAIT_CYCLES = SBUS_WAIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
`ifdef SBUS_RSP_PARITY_EN
    ,
    output logic                rsp_parity
`endif
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    sbus_state_e       r_state, w_state_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic              w_accept;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;

    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_enter_resp;
    logic              w_rsp_done;
    logic              w_op_we;
    logic [ADDR_W-1:0] w_op_addr;
    logic [DATA_W-1:0] w_op_wdata;
    logic [BE_W-1:0]   w_op_be;
    logic              w_op_in_range;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [DATA_W-1:0] w_rdata_next;
    logic              w_err_next;

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_next = RESP;
                    end else begin
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = RESP;
                end else begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);
    assign w_rsp_done   = (r_state == RESP) && rsp_ready;

    // With WAIT_CYCLES == 0 the access happens on the accept edge itself,
    // before the holding registers are loaded, so use the live request.
    assign w_op_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_op_be    = (r_state == IDLE) ? req_be    : r_be;

    assign w_op_in_range = ({1'b0, w_op_addr} < (ADDR_W+1)'(DEPTH));
    assign w_err_next    = !w_op_in_range;
    assign w_rdata_next  = (w_op_in_range && !w_op_we) ? w_mem_rdata : '0;

    sbus_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (w_enter_resp && w_op_we),
        .addr   (w_op_addr),
        .wdata  (w_op_wdata),
        .be     (w_op_be),
        .rdata  (w_mem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rdata <= w_rdata_next;
            r_err   <= w_err_next;
        end else if (w_rsp_done) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end
    end

`ifdef SBUS_RSP_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_enter_resp) begin
            r_parity <= ^{w_err_next, w_rdata_next};
        end else if (w_rsp_done) begin
            r_parity <= 1'b0;
        end
    end

    assign rsp_parity = r_parity;
`endif

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_sbus_responder.sv
// ---------------------------------------------------------------------------
// tb_sbus_responder
// Directed and randomized stimulus for sbus_responder, checked every cycle
// against a transaction-level model (memory array + response timer).
// ---------------------------------------------------------------------------
module tb_sbus_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 64;
    localparam int BE_W   = DATA_W / 8;
    parameter  int WAIT_CYCLES = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [BE_W-1:0]   req_be = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_parity;

    always #5 clk = ~clk;

    sbus_responder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
`ifdef SBUS_RSP_PARITY_EN
        ,
        .rsp_parity (rsp_parity)
`endif
    );

`ifndef SBUS_RSP_PARITY_EN
    assign rsp_parity = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit dut_acc = 1'b0;

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_busy;     // request accepted, response not yet up
    bit                m_rsp;      // response being presented
    bit                m_acc;      // model accepted on the last edge
    int                m_wl;       // edges left until the response appears
    logic [DATA_W-1:0] m_rdata;
    logic              m_err;
    bit                p_we;
    int                p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic [BE_W-1:0]   p_be;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_busy = 0; m_rsp = 0; m_acc = 0; m_wl = 0;
        m_rdata = '0; m_err = 1'b0;
    endtask

    task automatic model_resolve();
        m_busy = 0;
        m_rsp  = 1;
        if (p_addr < DEPTH) begin
            m_err = 1'b0;
            if (p_we) begin
                for (int b = 0; b < BE_W; b++)
                    if (p_be[b]) m_mem[p_addr][8*b +: 8] = p_wdata[8*b +: 8];
                m_rdata = '0;
            end else begin
                m_rdata = m_mem[p_addr];
            end
        end else begin
            m_err   = 1'b1;
            m_rdata = '0;
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        m_acc = 0;
        if (m_rsp) begin
            if (rsp_ready) begin
                m_rsp = 0; m_rdata = '0; m_err = 1'b0;
            end
        end else if (m_busy) begin
            m_wl--;
            if (m_wl == 0) model_resolve();
        end else if (req_valid) begin
            m_acc   = 1;
            p_we    = req_we;
            p_addr  = int'(req_addr);
            p_wdata = req_wdata;
            p_be    = req_be;
            m_busy  = 1;
            m_wl    = WAIT_CYCLES;
            if (m_wl == 0) model_resolve();
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("req_ready", req_ready, !(m_busy || m_rsp));
        chk("rsp_valid", rsp_valid, m_rsp);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err",   rsp_err,   m_err);
`ifdef SBUS_RSP_PARITY_EN
        chk("rsp_parity", rsp_parity, ^{m_err, m_rdata});
`endif
    endtask

    task automatic tick();
        dut_acc = req_ready && req_valid;
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_rsp_valid", rsp_valid, 1'b0);
        chk("rst_async_req_ready", req_ready, 1'b1);
        chk("rst_async_rdata", rsp_rdata, '0);
        chk("rst_async_err", rsp_err, 1'b0);
        model_reset();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One complete transaction; hold = cycles rsp_ready stays low in RESP.
    task automatic txn(input bit we, input int addr, input logic [DATA_W-1:0] wd,
                       input logic [BE_W-1:0] be, input int hold,
                       output logic [DATA_W-1:0] rd, output logic er, output logic pr);
        int g;
        int lat;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = ADDR_W'(addr);
        req_wdata = wd;
        req_be    = be;
        rsp_ready = (hold == 0);
        g = 0;
        do begin
            tick();
            g++;
        end while (!dut_acc && g < 20);
        chk("accept", dut_acc, 1'b1);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, WAIT_CYCLES);
        rd = rsp_rdata;
        er = rsp_err;
        pr = rsp_parity;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_rdata", rsp_rdata, rd);
        end
        rsp_ready = 1'b1;
        tick();
        chk("rsp_drop", rsp_valid, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] rd;
    logic              er;
    logic              pr;
    int                acc_cycles[$];

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("reset_req_ready", req_ready, 1'b1);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_rdata", rsp_rdata, 32'h0);
        chk("reset_rsp_err",   rsp_err,   1'b0);

        // Read of a cleared word
        txn(0, 8'h05, '0, '0, 0, rd, er, pr);
        chk("rd05_data", rd, 32'h0);
        chk("rd05_err",  er, 1'b0);

        // Byte-enable merge and read-after-write
        txn(1, 8'h10, 32'hDEADBEEF, 4'b1111, 0, rd, er, pr);
        chk("wr10_rdata_zero", rd, 32'h0);
        txn(1, 8'h10, 32'h000000AA, 4'b0001, 0, rd, er, pr);
        txn(0, 8'h10, '0, '0, 0, rd, er, pr);
        chk("rd10_merge", rd, 32'hDEADBEAA);

        // be = 0 write: normal response, no change
        txn(1, 8'h10, 32'h11111111, 4'b0000, 0, rd, er, pr);
        chk("be0_err", er, 1'b0);
        txn(0, 8'h10, '0, '0, 0, rd, er, pr);
        chk("be0_nochange", rd, 32'hDEADBEAA);

        // Range checks and no aliasing
        txn(1, 8'h3F, 32'hCAFEF00D, 4'b1111, 0, rd, er, pr);
        txn(0, 8'h40, '0, '0, 0, rd, er, pr);
        chk("rd40_err", er, 1'b1);
        chk("rd40_data", rd, 32'h0);
        txn(1, 8'h7F, 32'hFFFFFFFF, 4'b1111, 0, rd, er, pr);
        chk("wr7F_err", er, 1'b1);
        txn(0, 8'h3F, '0, '0, 0, rd, er, pr);
        chk("rd3F_data", rd, 32'hCAFEF00D);
        chk("rd3F_err", er, 1'b0);

        // Parity of a single set bit
        txn(1, 8'h01, 32'h00000001, 4'b1111, 0, rd, er, pr);
        txn(0, 8'h01, '0, '0, 0, rd, er, pr);
        chk("rd01_data", rd, 32'h1);
`ifdef SBUS_RSP_PARITY_EN
        chk("rd01_parity", pr, 1'b1);
`endif

        // Backpressure with a competing request held on the bus
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; rsp_ready = 1'b0;
        begin
            int g;
            g = 0;
            do begin tick(); g++; end while (!dut_acc && g < 20);
            chk("bp_accept", dut_acc, 1'b1);
            req_addr = 8'h3F;
            g = 0;
            while (!rsp_valid && g < 20) begin tick(); g++; end
            chk("bp_rdata", rsp_rdata, 32'hDEADBEAA);
            for (int i = 0; i < 5; i++) begin
                tick();
                chk("bp_hold_valid", rsp_valid, 1'b1);
                chk("bp_hold_rdata", rsp_rdata, 32'hDEADBEAA);
                chk("bp_no_accept", dut_acc, 1'b0);
            end
            rsp_ready = 1'b1;
            tick();
            chk("bp_release_no_accept", dut_acc, 1'b0);
            chk("bp_release_idle", req_ready, 1'b1);
            tick();
            chk("bp_accept_after", dut_acc, 1'b1);
            req_valid = 1'b0;
            g = 0;
            while (!rsp_valid && g < 20) begin tick(); g++; end
            chk("bp_second_rdata", rsp_rdata, 32'hCAFEF00D);
            tick();
        end

        // Back-to-back requests: accepts spaced WAIT_CYCLES+2 apart
        req_valid = 1'b1; req_we = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 5 * (WAIT_CYCLES + 2); i++) begin
            req_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            tick();
            if (dut_acc) acc_cycles.push_back(cyc);
        end
        req_valid = 1'b0;
        chk("b2b_accept_count", acc_cycles.size() >= 4, 1'b1);
        for (int i = 1; i < acc_cycles.size(); i++)
            chk("b2b_spacing", acc_cycles[i] - acc_cycles[i-1], WAIT_CYCLES + 2);
        repeat (WAIT_CYCLES + 3) tick();

        // Reset while a write is in flight discards it
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20;
        req_wdata = 32'h12345678; req_be = 4'b1111;
        tick();
        chk("rstw_accept", dut_acc, 1'b1);
        req_valid = 1'b0;
        do_reset();
        tick();
        txn(0, 8'h20, '0, '0, 0, rd, er, pr);
        chk("rstw_rd20", rd, 32'h0);
        txn(0, 8'h10, '0, '0, 0, rd, er, pr);
        chk("rstw_rd10_cleared", rd, 32'h0);

        // Reset while a response is being held
        txn(1, 8'h02, 32'hA5A5A5A5, 4'b1111, 0, rd, er, pr);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h02; rsp_ready = 1'b0;
        begin
            int g;
            g = 0;
            do begin tick(); g++; end while (!dut_acc && g < 20);
            req_valid = 1'b0;
            g = 0;
            while (!rsp_valid && g < 20) begin tick(); g++; end
            chk("rstr_rdata", rsp_rdata, 32'hA5A5A5A5);
        end
        do_reset();
        tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_we    = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0)
                req_addr = ADDR_W'($urandom_range(0, 255));
            else
                req_addr = ADDR_W'($urandom_range(0, DEPTH + 7));
            req_wdata = $urandom;
            req_be    = BE_W'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
